// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master data-memory arbiter.
//   state_e     : arbiter FSM state encoding (idle / grant / release).
//   owner_e     : grant owner code (m0 = D-cache, m1 = I-cache).
//   pick_winner : resolves a request pair to a single owner, fixed or round-robin.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  typedef enum logic {
    OwnM0 = 1'b0,
    OwnM1 = 1'b1
  } owner_e;

  localparam int unsigned WdW = 8;

  // Contention goes to whoever was not served last when rr_en is set, else m0.
  // A lone requester always wins.
  function automatic owner_e pick_winner(input logic r0, input logic r1,
                                         input owner_e last, input logic rr_en);
    owner_e win;
    if (r0 && r1) begin
      win = (rr_en && (last == OwnM0)) ? OwnM1 : OwnM0;
    end else if (r0) begin
      win = OwnM0;
    end else begin
      win = OwnM1;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single cache-line data-memory port.
// m0 = D-cache controller (read/write), m1 = I-cache controller (read only).
// A grant is held for a whole enable->ack transaction, followed by one idle
// RELEASE cycle so the served master can drop its registered enable.
// A watchdog raises a sticky err_o when memory never acknowledges.
//
// Build option: define MEM_ARB_RR_EN for round-robin on contention; otherwise
// fixed priority m0 > m1.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   m0_enable_i/write_i/addr_i/data_i, m0_ack_o   D-cache side
//   m1_enable_i/addr_i, m1_ack_o                  I-cache side
//   mem_data_i, mem_ack_i                         memory response
//   mem_enable_o/write_o/addr_o/data_o            memory request
//   rd_data_o            memory read data broadcast to both masters
//   grant_o              one-hot owner {m1,m0}, 00 when none
//   err_o                sticky watchdog error
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam logic [WdW-1:0] TimeoutCnt = WdW'(TIMEOUT_CYC);
  localparam logic [WdW-1:0] WdMax      = '1;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  owner_e         winner;
  logic           owner_en;
  logic           in_grant;
  logic           sel_m1;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  assign winner = pick_winner(m0_enable_i, m1_enable_i, last_q, 1'b1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= OwnM1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign winner = pick_winner(m0_enable_i, m1_enable_i, OwnM1, 1'b0);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      owner_q <= OwnM0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign owner_en = (owner_q == OwnM1) ? m1_enable_i : m0_enable_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    err_d   = err_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_enable_i || m1_enable_i) begin
          owner_d = winner;
          wd_d    = '0;
          state_d = StGrant;
`ifdef MEM_ARB_RR_EN
          last_d  = winner;
`endif
        end
      end
      StGrant: begin
        if (mem_ack_i) begin
          state_d = StRelease;
        end else begin
          if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
          end
          if (wd_q + 1'b1 == TimeoutCnt) begin
            err_d = 1'b1;
          end
          // Owner withdrew (e.g. its controller was reset): abandon without ack.
          if (!owner_en) begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory-side mux is purely combinational so an async reset clears it at once.
  assign in_grant     = (state_q == StGrant);
  assign sel_m1       = (owner_q == OwnM1);
  assign mem_enable_o = in_grant;
  assign mem_write_o  = in_grant && !sel_m1 && m0_write_i;
  assign mem_addr_o   = !in_grant ? '0 : (sel_m1 ? m1_addr_i : m0_addr_i);
  assign mem_data_o   = (in_grant && !sel_m1) ? m0_data_i : '0;
  assign m0_ack_o     = in_grant && !sel_m1 && mem_ack_i;
  assign m1_ack_o     = in_grant && sel_m1 && mem_ack_i;
  assign grant_o      = in_grant ? {sel_m1, !sel_m1} : 2'b00;
  assign rd_data_o    = mem_data_i;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transactions push expected
// acknowledges into a scoreboard, a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_en, m0_wr, m1_en, mem_ack;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_data, mem_rdata;
  logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, rd_data_o;
  logic [1:0]    grant_o;

  typedef struct {
    logic [1:0]    grant;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_seq   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .m0_enable_i (m0_en),
    .m0_write_i  (m0_wr),
    .m0_addr_i   (m0_addr),
    .m0_data_i   (m0_data),
    .m0_ack_o    (m0_ack_o),
    .m1_enable_i (m1_en),
    .m1_addr_i   (m1_addr),
    .m1_ack_o    (m1_ack_o),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .rd_data_o   (rd_data_o),
    .grant_o     (grant_o),
    .err_o       (err_o)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every acknowledge the DUT raises must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (m0_ack_o || m1_ack_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", DW'({m1_ack_o, m0_ack_o}), '0);
      end else begin
        e = sb.pop_front();
        check("ack_owner", DW'({m1_ack_o, m0_ack_o}), DW'(e.grant));
        check("ack_grant", DW'(grant_o), DW'(e.grant));
        check("ack_write", DW'(mem_write_o), DW'(e.write));
        check("ack_addr", DW'(mem_addr_o), DW'(e.addr));
        check("ack_wdata", mem_data_o, e.data);
        check("ack_rdata", rd_data_o, e.rdata);
      end
    end
  end

  // Entered at the start of an IDLE cycle with requests already driven.
  // lat = GRANT cycles before ack; keep = owner leaves its enable high afterwards.
  task automatic txn(input logic exp_m1, input logic exp_wr, input logic [AW-1:0] exp_addr,
                     input logic [DW-1:0] exp_data, input int lat, input logic keep);
    exp_t e;
    smp();
    check("idle_en", DW'(mem_enable_o), '0);
    check("idle_grant", DW'(grant_o), '0);
    tick();
    rd_seq++;
    e.grant = exp_m1 ? 2'b10 : 2'b01;
    e.write = exp_wr;
    e.addr  = exp_addr;
    e.data  = exp_data;
    e.rdata = {8{32'hC0DE_0000 + 32'(rd_seq)}};
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      smp();
      check("grant_en", DW'(mem_enable_o), DW'(1'b1));
      check("grant_owner", DW'(grant_o), DW'(e.grant));
      check("grant_noack", DW'({m1_ack_o, m0_ack_o}), '0);
      tick();
    end
    mem_rdata = e.rdata;
    mem_ack   = 1'b1;
    smp();
    tick();
    mem_ack = 1'b0;
    if (!keep) begin
      if (exp_m1) m1_en = 1'b0;
      else        m0_en = 1'b0;
    end
    smp();
    check("release_en", DW'(mem_enable_o), '0);
    check("release_grant", DW'(grant_o), '0);
    tick();
  endtask

  initial begin : limit
    #2_000_000;
    $display("FAIL sim_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin : stim
    logic rr;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 1'b0; m0_en = 0; m0_wr = 0; m1_en = 0; mem_ack = 0;
    m0_addr = '0; m1_addr = '0; m0_data = '0; mem_rdata = '0;
    smp();
    check("rst_en", DW'(mem_enable_o), '0);
    check("rst_grant", DW'(grant_o), '0);
    check("rst_write", DW'(mem_write_o), '0);
    check("rst_addr", DW'(mem_addr_o), '0);
    check("rst_wdata", mem_data_o, '0);
    check("rst_acks", DW'({m1_ack_o, m0_ack_o}), '0);
    check("rst_err", DW'(err_o), '0);
    tick();
    rst_n = 1'b1;
    tick();

    // m0 read alone, ack in the 11th GRANT cycle.
    m0_en = 1; m0_wr = 0; m0_addr = 32'h0000_0400;
    txn(1'b0, 1'b0, 32'h0000_0400, '0, 10, 1'b0);

    // Memory ack while idle must go nowhere.
    mem_ack = 1'b1;
    smp();
    check("idle_ack_ignored", DW'({m1_ack_o, m0_ack_o}), '0);
    tick();
    mem_ack = 1'b0;
    smp();
    check("idle_stays", DW'(mem_enable_o), '0);
    tick();

    // Contention; last owner is m0 so round-robin serves m1 first.
    m0_en = 1; m0_addr = 32'h0000_0800; m1_en = 1; m1_addr = 32'h0000_1000;
    if (rr) begin
      txn(1'b1, 1'b0, 32'h0000_1000, '0, 3, 1'b0);
      txn(1'b0, 1'b0, 32'h0000_0800, '0, 2, 1'b0);
    end else begin
      txn(1'b0, 1'b0, 32'h0000_0800, '0, 3, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_1000, '0, 2, 1'b0);
    end

    // Lone m1 request, then contention again: m0 wins in both modes.
    m1_en = 1; m1_addr = 32'h0000_2000;
    txn(1'b1, 1'b0, 32'h0000_2000, '0, 1, 1'b0);
    m0_en = 1; m0_addr = 32'h0000_0840; m1_en = 1; m1_addr = 32'h0000_2040;
    txn(1'b0, 1'b0, 32'h0000_0840, '0, 2, 1'b0);
    txn(1'b1, 1'b0, 32'h0000_2040, '0, 0, 1'b0);

    // Write-back then refill with enable held high throughout.
    m0_en = 1; m0_wr = 1; m0_addr = 32'h0000_3000; m0_data = {32{8'hA5}};
    txn(1'b0, 1'b1, 32'h0000_3000, {32{8'hA5}}, 4, 1'b1);
    m0_wr = 0; m0_data = '0;
    txn(1'b0, 1'b0, 32'h0000_3000, '0, 3, 1'b0);

    // m1 abandons mid-grant: release without ack.
    m1_en = 1; m1_addr = 32'h0000_5000;
    smp();
    tick();
    smp();
    check("abandon_grant", DW'(grant_o), DW'(2'b10));
    tick();
    m1_en = 0;
    smp();
    check("abandon_still_grant", DW'(grant_o), DW'(2'b10));
    tick();
    smp();
    check("abandon_release", DW'(mem_enable_o), '0);
    tick();

    // Watchdog: no ack; err after 255 GRANT cycles, sticky, grant kept.
    m0_en = 1; m0_addr = 32'h0000_6000;
    smp();
    tick();
    for (int i = 0; i < 260; i++) begin
      smp();
      check("wd_err", DW'(err_o), DW'(i >= 255));
      if (i == 0 || i >= 254) check("wd_grant", DW'(grant_o), DW'(2'b01));
      if (i < 259) tick();
    end

    // Asynchronous reset mid-grant.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", DW'(mem_enable_o), '0);
    check("arst_grant", DW'(grant_o), '0);
    check("arst_err", DW'(err_o), '0);
    check("arst_addr", DW'(mem_addr_o), '0);
    m0_en = 0;
    tick();
    rst_n = 1'b1;
    smp();
    check("post_rst_err", DW'(err_o), '0);
    check("post_rst_en", DW'(mem_enable_o), '0);
    tick();

    check("sb_empty", DW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
